// File: rtl/pixel_pkg.sv
// pixel_pkg: shared definitions for the pixel FIFO reader slice.
//   - 38-bit pixel word layout: [37:27] x, [26:16] y, [15:0] RGB565
//   - FSM state enum (SEARCH / LOCKED)
//   - 8-entry RGB565 colour-bar table used by the optional test pattern
//   - small field accessors
package pixel_pkg;

    localparam int unsigned WORD_W  = 38;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned RGB_W   = 16;

    localparam int unsigned X_MSB   = 37;
    localparam int unsigned X_LSB   = 27;
    localparam int unsigned Y_MSB   = 26;
    localparam int unsigned Y_LSB   = 16;
    localparam int unsigned RGB_MSB = 15;
    localparam int unsigned RGB_LSB = 0;

    typedef logic [WORD_W-1:0]  pixel_word_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam rgb_t COLOUR_BARS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    function automatic coord_t word_x(input pixel_word_t w);
        return w[X_MSB:X_LSB];
    endfunction

    function automatic coord_t word_y(input pixel_word_t w);
        return w[Y_MSB:Y_LSB];
    endfunction

endpackage

// File: rtl/pixel_fifo_reader_if.sv
// pixel_fifo_reader_if: bundle of the ADC-side (read) and DAC-side (write)
// FIFO handshake signals.
//   master : the reader - drives in_fifo_rd_en, out_fifo_data, out_fifo_wr_en
//   slave  : the FIFO side - drives in_fifo_data, in_fifo_empty, out_fifo_full
interface pixel_fifo_reader_if;
    import pixel_pkg::*;

    pixel_word_t in_fifo_data;
    logic        in_fifo_empty;
    logic        in_fifo_rd_en;
    pixel_word_t out_fifo_data;
    logic        out_fifo_wr_en;
    logic        out_fifo_full;

    modport master (
        input  in_fifo_data,
        input  in_fifo_empty,
        input  out_fifo_full,
        output in_fifo_rd_en,
        output out_fifo_data,
        output out_fifo_wr_en
    );

    modport slave (
        output in_fifo_data,
        output in_fifo_empty,
        output out_fifo_full,
        input  in_fifo_rd_en,
        input  out_fifo_data,
        input  out_fifo_wr_en
    );

endinterface

// File: rtl/pixel_hold_reg.sv
// pixel_hold_reg: single-word hold register between the ADC-side FIFO and
// the DAC-side FIFO, including the read/write handshakes.
// Ports:
//   clk160, rst      : clock, synchronous active-high reset
//   fifo             : FIFO handshake bundle (master side)
//   cap_word         : word to capture (FIFO data, possibly recoloured)
//   drop             : the held word is to be discarded rather than written
//   hold_x, hold_y   : coordinates of the held word
//   hold_valid       : hold register occupied
//   take             : held word leaves this cycle (written or dropped)
module pixel_hold_reg
    import pixel_pkg::*;
(
    input  logic                 clk160,
    input  logic                 rst,
    pixel_fifo_reader_if.master  fifo,
    input  pixel_word_t          cap_word,
    input  logic                 drop,
    output coord_t               hold_x,
    output coord_t               hold_y,
    output logic                 hold_valid,
    output logic                 take
);

    logic        pending;
    logic        valid_q;
    pixel_word_t hold_q;

    // A read may be issued in the same cycle the held word leaves; with
    // out_fifo_full low a valid hold always leaves (write or drop), which
    // gives one word every two cycles while never overwriting a held word.
    assign fifo.in_fifo_rd_en  = !rst && !fifo.in_fifo_empty && !pending &&
                                 (!valid_q || !fifo.out_fifo_full);
    assign fifo.out_fifo_wr_en = !rst && valid_q && !drop && !fifo.out_fifo_full;
    assign take                = !rst && valid_q && (drop || !fifo.out_fifo_full);

    assign fifo.out_fifo_data  = hold_q;
    assign hold_x              = word_x(hold_q);
    assign hold_y              = word_y(hold_q);
    assign hold_valid          = valid_q;

    always_ff @(posedge clk160) begin
        if (rst) begin
            pending <= 1'b0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            pending <= fifo.in_fifo_rd_en;
            if (pending) begin
                hold_q  <= cap_word;
                valid_q <= 1'b1;
            end else if (take) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pixel_fifo_reader.sv
// pixel_fifo_reader: moves pixel words from the ADC-side FIFO to the
// DAC-side FIFO, dropping words until a frame start (0,0) is seen and
// afterwards dropping out-of-range words and words that step back in y.
// Optional feature macro: PIXEL_FIFO_READER_TEST_PATTERN_EN adds a
// test_pattern input that replaces RGB with colour bars selected by x[9:7].
// Ports:
//   clk160, rst   : clock, synchronous active-high reset
//   fifo          : FIFO handshake bundle (master side)
//   test_pattern  : (macro only) recolour forwarded words
//   frame_locked  : FSM is in LOCKED
//   frame_count   : frames started since reset (wraps)
//   drop_count    : words discarded since reset (saturates)
module pixel_fifo_reader
    import pixel_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600
) (
    input  logic                 clk160,
    input  logic                 rst,
    pixel_fifo_reader_if.master  fifo,
`ifdef PIXEL_FIFO_READER_TEST_PATTERN_EN
    input  logic                 test_pattern,
`endif
    output logic                 frame_locked,
    output logic [15:0]          frame_count,
    output logic [15:0]          drop_count
);

    state_t      state_q, state_d;
    coord_t      last_y_q;
    pixel_word_t cap_word;
    coord_t      hold_x, hold_y;
    logic        hold_valid, take;
    logic        drop, fwd, frame_inc, origin;

`ifdef PIXEL_FIFO_READER_TEST_PATTERN_EN
    coord_t in_x;

    always_comb begin
        in_x     = word_x(fifo.in_fifo_data);
        cap_word = fifo.in_fifo_data;
        if (test_pattern) begin
            cap_word[RGB_MSB:RGB_LSB] = COLOUR_BARS[in_x[9:7]];
        end
    end
`else
    assign cap_word = fifo.in_fifo_data;
`endif

    pixel_hold_reg u_hold (
        .clk160     (clk160),
        .rst        (rst),
        .fifo       (fifo),
        .cap_word   (cap_word),
        .drop       (drop),
        .hold_x     (hold_x),
        .hold_y     (hold_y),
        .hold_valid (hold_valid),
        .take       (take)
    );

    // Classify the held word; effects are committed only when it leaves.
    always_comb begin
        state_d   = state_q;
        drop      = 1'b0;
        fwd       = 1'b0;
        frame_inc = 1'b0;
        origin    = (hold_x == '0) && (hold_y == '0);
        if (hold_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (origin) begin
                        fwd       = 1'b1;
                        frame_inc = 1'b1;
                        state_d   = LOCKED;
                    end else begin
                        drop = 1'b1;
                    end
                end
                LOCKED: begin
                    if (32'(hold_x) >= H_ACTIVE || 32'(hold_y) >= V_ACTIVE) begin
                        drop = 1'b1;
                    end else if (!origin && hold_y < last_y_q) begin
                        drop    = 1'b1;
                        state_d = SEARCH;
                    end else begin
                        fwd       = 1'b1;
                        frame_inc = origin;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk160) begin
        if (rst) begin
            state_q     <= SEARCH;
            last_y_q    <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else if (take) begin
            state_q <= state_d;
            if (fwd) begin
                last_y_q <= hold_y;
            end
            if (frame_inc) begin
                frame_count <= frame_count + 16'd1;
            end
            if (drop && drop_count != '1) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign frame_locked = (state_q == LOCKED);

endmodule
